aes_round_sched: RTL



---
 rtl/aes_round_sched_if.sv | 37 +++
 rtl/aes_round_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sched_if.sv
// Block-in / round-step / result-out bus between the round scheduler and its host + datapath.
// Latency: none, plain wires.
// Backpressure: blk_valid/blk_ready on the input side, out_valid/out_ready on the result side.
interface aes_round_sched_if;
    logic         blk_valid;
    logic         blk_ready;
    logic         round_en;
    logic [1:0]   round_type;
    logic [3:0]   round_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;

    // Scheduler side.
    modport master (
        input  blk_valid,
        input  out_ready,
        output blk_ready,
        output round_en,
        output round_type,
        output round_idx,
        output round_key,
        output out_valid
    );

    // Host / datapath side.
    modport slave (
        output blk_valid,
        output out_ready,
        input  blk_ready,
        input  round_en,
        input  round_type,
        input  round_idx,
        input  round_key,
        input  out_valid
    );
endinterface

// File: rtl/aes_round_sched.sv
// Sequences AES key expansion and steps the round datapath through rounds 0..Nr per block.
// Latency: block accepted at T -> round_en T+1..T+Nr+1 -> out_valid from T+Nr+2 (plus key-valid stalls).
// Backpressure: out_valid holds until out_ready; blk_ready only in READY with no key reload pending.
module aes_round_sched #(
    parameter int KREQ_CYCLES = 2,
    parameter int KX_SETTLE   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic [3:0]        key_nk,
    output logic [3:0]        kx_nk,
    output logic              kx_k_ready,
    output logic [3:0]        kx_addr,
    input  logic [128:0]      kx_key,
    aes_round_sched_if.master bus,
    output logic              key_ok,
    output logic              nk_err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_KSET,
        S_KREQ,
        S_KWAIT,
        S_READY,
        S_ROUND,
        S_OUT
    } state_t;

    localparam logic [4:0] KREQ_LAST = 5'(KREQ_CYCLES - 1);
    localparam logic [4:0] SETTLE    = 5'(KX_SETTLE);

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic [4:0]  wait_last;
    logic [3:0]  nr;
    logic [3:0]  nr_of_nk;
    logic [3:0]  nk_lat;
    logic [3:0]  round_idx;
    logic        key_pend;
    logic        nk_legal;
    logic        key_vld;
    logic        last_round;
    logic        busy_load;
    logic        go_kset;
    logic        blk_acc;
    logic        kwait_done;
    logic        blk_ready;
    logic        round_en;
    logic [1:0]  round_type;
    logic        out_valid;

    // Round count for the Nk code held in kx_nk; zero flags an illegal code.
    always_comb begin
        case (kx_nk)
            4'd3:    nr_of_nk = 4'd10;
            4'd5:    nr_of_nk = 4'd12;
            4'd7:    nr_of_nk = 4'd14;
            default: nr_of_nk = 4'd0;
        endcase
    end

    assign nk_legal   = (nr_of_nk != 4'd0);
    assign key_vld    = kx_key[128];
    assign last_round = (round_idx == nr);
    // KWAIT lasts Nr+KX_SETTLE cycles; cnt saturates on the last one while the key is not yet valid.
    assign wait_last  = {1'b0, nr} + SETTLE - 5'd1;
    // A reload arriving while busy is remembered and served once the FSM is back in READY.
    assign busy_load  = key_load && (state inside {S_KSET, S_KREQ, S_KWAIT, S_ROUND, S_OUT});

    assign bus.blk_ready  = blk_ready;
    assign bus.round_en   = round_en;
    assign bus.round_type = round_type;
    assign bus.round_idx  = round_idx;
    assign bus.round_key  = round_en ? kx_key[127:0] : 128'd0;
    assign bus.out_valid  = out_valid;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_nxt  = state;
        kx_k_ready = 1'b0;
        kx_addr    = 4'd0;
        blk_ready  = 1'b0;
        round_en   = 1'b0;
        round_type = 2'd0;
        out_valid  = 1'b0;
        go_kset    = 1'b0;
        blk_acc    = 1'b0;
        kwait_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (key_load || key_pend) begin
                    go_kset   = 1'b1;
                    state_nxt = S_KSET;
                end
            end
            S_KSET: begin
                state_nxt = nk_legal ? S_KREQ : S_IDLE;
            end
            S_KREQ: begin
                kx_k_ready = 1'b1;
                if (cnt == KREQ_LAST) state_nxt = S_KWAIT;
            end
            S_KWAIT: begin
                kx_addr = nr;
                if (cnt == wait_last && key_vld) begin
                    kwait_done = 1'b1;
                    state_nxt  = S_READY;
                end
            end
            S_READY: begin
                // A same-cycle key_load wins over the block, so do not offer ready then either.
                blk_ready = !key_pend && !key_load;
                if (key_pend || key_load) begin
                    go_kset   = 1'b1;
                    state_nxt = S_KSET;
                end else if (bus.blk_valid) begin
                    blk_acc   = 1'b1;
                    state_nxt = S_ROUND;
                end
            end
            S_ROUND: begin
                kx_addr  = round_idx;
                round_en = key_vld;
                if (key_vld) begin
                    if (round_idx == 4'd0) round_type = 2'd0;
                    else if (last_round)   round_type = 2'd2;
                    else                   round_type = 2'd1;
                    if (last_round) state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = S_READY;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shared KREQ/KWAIT cycle counter, cleared on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                cnt <= 5'd0;
        else if (state_nxt != state)               cnt <= 5'd0;
        else if (state == S_KREQ)                  cnt <= cnt + 5'd1;
        else if (state == S_KWAIT && cnt != wait_last) cnt <= cnt + 5'd1;
    end

    // Key bookkeeping: Nk capture, pending reload, key usability and illegal-Nk flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx_nk    <= 4'd0;
            nk_lat   <= 4'd0;
            nr       <= 4'd0;
            key_pend <= 1'b0;
            key_ok   <= 1'b0;
            nk_err   <= 1'b0;
        end else begin
            if (key_load) nk_lat <= key_nk;
            // kx_nk is loaded on entry to KSET so it is stable a full cycle before kx_k_ready.
            if (go_kset) kx_nk <= key_load ? key_nk : nk_lat;
            if (go_kset)        key_pend <= 1'b0;
            else if (busy_load) key_pend <= 1'b1;
            if (go_kset)         key_ok <= 1'b0;
            else if (kwait_done) key_ok <= 1'b1;
            if (state == S_KSET) begin
                nk_err <= !nk_legal;
                if (nk_legal) nr <= nr_of_nk;
            end
        end
    end

    // Round index: reset on block accept, advance only on rounds the key memory qualified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       round_idx <= 4'd0;
        else if (blk_acc)                 round_idx <= 4'd0;
        else if (round_en && !last_round) round_idx <= round_idx + 4'd1;
    end
endmodule
